// File: rtl/gen_scope_writer.sv
// 2-D register file built from nested named generate scopes (blk1.row[i].col[j].c),
// self-initialised after reset, written through valid/ready, read through a registered port.
// Define GEN_SCOPE_ASSERT_EN to add the shadow array and hierarchical-name consistency asserts.
module gen_scope_writer #(
  parameter  int NI    = 2,
  parameter  int NJ    = 2,
  parameter  int WIDTH = 8,
  localparam int IW    = (NI > 1) ? $clog2(NI) : 1,
  localparam int JW    = (NJ > 1) ? $clog2(NJ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IW-1:0]    wr_i,
  input  logic [JW-1:0]    wr_j,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IW-1:0]    rd_i,
  input  logic [JW-1:0]    rd_j,
  output logic [WIDTH-1:0] rd_data,
  output logic             init_done,
  output logic             wr_err
);

  // state  | meaning
  // INIT   | sweeping cell k with value k, one cell per cycle
  // IDLE   | ready for a host write
  // COMMIT | writing the captured host payload into its cell

  localparam int NC = NI * NJ;
  localparam int KW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {INIT, IDLE, COMMIT} state_t;

  state_t state_q, state_d;

  logic [KW-1:0]    k;
  logic [IW-1:0]    ki;
  logic [JW-1:0]    kj;
  logic [IW-1:0]    cap_i;
  logic [JW-1:0]    cap_j;
  logic [WIDTH-1:0] cap_data;
  logic             cap_oor;

  logic             wen;
  logic [IW-1:0]    wsel_i;
  logic [JW-1:0]    wsel_j;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] cells [NC];
  logic [WIDTH-1:0] rd_next;

  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    wen      = 1'b0;
    wsel_i   = ki;
    wsel_j   = kj;
    wdata    = WIDTH'(k);
    case (state_q)
      INIT: begin
        wen = 1'b1;
        if (k == KW'(NC - 1)) state_d = IDLE;
      end
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) state_d = COMMIT;
      end
      COMMIT: begin
        wen     = 1'b1;
        wsel_i  = cap_i;
        wsel_j  = cap_j;
        wdata   = cap_data;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // Out-of-range coordinates never match any cell decode, so only the flag needs them.
  assign cap_oor = ({1'b0, cap_i} >= (IW + 1)'(NI)) || ({1'b0, cap_j} >= (JW + 1)'(NJ));

  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      ki        <= '0;
      kj        <= '0;
      cap_i     <= '0;
      cap_j     <= '0;
      cap_data  <= '0;
      init_done <= 1'b0;
      wr_err    <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (state_q == INIT) begin
        if (k == KW'(NC - 1)) begin
          init_done <= 1'b1;
        end else begin
          k <= k + 1'b1;
          if (kj == JW'(NJ - 1)) begin
            kj <= '0;
            ki <= ki + 1'b1;
          end else begin
            kj <= kj + 1'b1;
          end
        end
      end
      if (state_q == IDLE && wr_valid) begin
        cap_i    <= wr_i;
        cap_j    <= wr_j;
        cap_data <= wr_data;
      end
      if (state_q == COMMIT && cap_oor) wr_err <= 1'b1;
      rd_data <= rd_next;
    end
  end

  // Unmatched (out-of-range) read coordinates fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int a = 0; a < NI; a++) begin
      for (int b = 0; b < NJ; b++) begin
        if (rd_i == IW'(a) && rd_j == JW'(b)) rd_next = cells[a*NJ + b];
      end
    end
  end

  if (1) begin : blk1
`ifdef GEN_SCOPE_ASSERT_EN
    logic [WIDTH-1:0] shadow [NC];

    always_ff @(posedge clk) begin
      for (int a = 0; a < NI; a++) begin
        for (int b = 0; b < NJ; b++) begin
          if (rst)
            shadow[a*NJ + b] <= '0;
          else if (wen && wsel_i == IW'(a) && wsel_j == JW'(b))
            shadow[a*NJ + b] <= wdata;
        end
      end
    end

    always @* begin
      if (init_done) assert (state_q == IDLE || state_q == COMMIT);
    end
`endif

    for (genvar i = 0; i < NI; i++) begin : row
      for (genvar j = 0; j < NJ; j++) begin : col
        logic [WIDTH-1:0] c;
        logic             we;

        assign we = wen && (wsel_i == IW'(i)) && (wsel_j == JW'(j));

        always_ff @(posedge clk) begin
          if (rst)     c <= '0;
          else if (we) c <= wdata;
        end

        assign cells[i*NJ + j] = c;

`ifdef GEN_SCOPE_ASSERT_EN
        always @* begin
          assert (c == col[j].c);
          assert (c == row[i].col[j].c);
          assert (c == blk1.row[i].col[j].c);
          assert (c == gen_scope_writer.blk1.row[i].col[j].c);
          assert (c == blk1.shadow[i*NJ + j]);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_gen_scope_writer.sv
// Directed bench for gen_scope_writer with NI=3, NJ=2, WIDTH=8 so out-of-range rows are expressible.
module tb_gen_scope_writer;

  localparam int NI = 3;
  localparam int NJ = 2;
  localparam int NC = NI * NJ;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_i = '0;
  logic [0:0] wr_j = '0;
  logic [7:0] wr_data = '0;
  logic [1:0] rd_i = '0;
  logic [0:0] rd_j = '0;
  logic [7:0] rd_data;
  logic       init_done;
  logic       wr_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_c [NC];

  gen_scope_writer #(.NI(NI), .NJ(NJ), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_i(wr_i), .wr_j(wr_j), .wr_data(wr_data),
    .rd_i(rd_i), .rd_j(rd_j), .rd_data(rd_data),
    .init_done(init_done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input int i, input int j, output logic [7:0] v);
    rd_i = 2'(i);
    rd_j = 1'(j);
    tick();
    v = rd_data;
  endtask

  // Returns one ns after the handshake edge, with the FSM in COMMIT.
  task automatic do_write(input int i, input int j, input logic [7:0] d);
    int n = 0;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: wr_ready=%b after %0d cycles, required 1", wr_ready, n);
    end
    wr_i = 2'(i);
    wr_j = 1'(j);
    wr_data = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    if (i < NI && j < NJ) exp_c[i*NJ + j] = d;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    tick();
    checks++;
    if (wr_ready !== 1'b0 || init_done !== 1'b0 || wr_err !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b done=%b err=%b rd=%h, required 0 0 0 00",
               wr_ready, init_done, wr_err, rd_data);
    end
    rst = 1'b0;
    for (int k = 0; k < NC; k++) exp_c[k] = 8'(k);
    repeat (NC - 1) tick();
    checks++;
    if (init_done !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL init_early: done=%b ready=%b at edge R+%0d, required 0 0", init_done, wr_ready, NC - 1);
    end
    tick();
    checks++;
    if (init_done !== 1'b1 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL init_done: done=%b ready=%b at edge R+%0d, required 1 1", init_done, wr_ready, NC);
    end
    for (int k = 0; k < NC; k++) begin
      read_cell(k / NJ, k % NJ, v);
      checks++;
      if (v !== 8'(k)) begin
        errors++;
        $display("FAIL init_cell(%0d,%0d): got %h, required %h", k / NJ, k % NJ, v, 8'(k));
      end
    end
  endtask

  task automatic test_single_write();
    logic [7:0] v;
    rd_i = 2'd1;
    rd_j = 1'd0;
    do_write(1, 0, 8'hA5);
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_low: wr_ready=%b in commit, required 0", wr_ready);
    end
    tick();
    checks++;
    if (wr_ready !== 1'b1 || rd_data !== 8'h02) begin
      errors++;
      $display("FAIL single_t1: ready=%b rd=%h, required 1 02", wr_ready, rd_data);
    end
    tick();
    checks++;
    if (rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_t2: rd=%h, required a5", rd_data);
    end
    for (int k = 0; k < NC; k++) begin
      read_cell(k / NJ, k % NJ, v);
      checks++;
      if (v !== exp_c[k]) begin
        errors++;
        $display("FAIL single_cells(%0d,%0d): got %h, required %h", k / NJ, k % NJ, v, exp_c[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    int n = 0;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    wr_i = 2'd0; wr_j = 1'd0; wr_data = 8'h3C;
    wr_valid = 1'b1;
    tick();
    wr_i = 2'd2; wr_j = 1'd1; wr_data = 8'h7E;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_commit: wr_ready=%b, required 0", wr_ready);
    end
    tick();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_gap: wr_ready=%b, required 1", wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_commit: wr_ready=%b, required 0", wr_ready);
    end
    tick();
    exp_c[0] = 8'h3C;
    exp_c[5] = 8'h7E;
    for (int k = 0; k < NC; k++) begin
      read_cell(k / NJ, k % NJ, v);
      checks++;
      if (v !== exp_c[k]) begin
        errors++;
        $display("FAIL b2b_cells(%0d,%0d): got %h, required %h", k / NJ, k % NJ, v, exp_c[k]);
      end
    end
  endtask

  task automatic test_same_edge();
    rd_i = 2'd1;
    rd_j = 1'd1;
    do_write(1, 1, 8'h5A);
    tick();
    checks++;
    if (rd_data !== 8'h03) begin
      errors++;
      $display("FAIL same_edge_old: rd=%h, required 03", rd_data);
    end
    tick();
    checks++;
    if (rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL same_edge_new: rd=%h, required 5a", rd_data);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] v;
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_err_before: wr_err=%b, required 0", wr_err);
    end
    do_write(3, 1, 8'h11);
    tick();
    checks++;
    if (wr_err !== 1'b1 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_err_set: wr_err=%b ready=%b, required 1 1", wr_err, wr_ready);
    end
    read_cell(3, 1, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL oor_read: got %h, required 00", v);
    end
    for (int k = 0; k < NC; k++) begin
      read_cell(k / NJ, k % NJ, v);
      checks++;
      if (v !== exp_c[k]) begin
        errors++;
        $display("FAIL oor_cells(%0d,%0d): got %h, required %h", k / NJ, k % NJ, v, exp_c[k]);
      end
    end
    checks++;
    if (wr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky: wr_err=%b, required 1", wr_err);
    end
  endtask

  task automatic test_reset_in_commit();
    logic [7:0] v;
    int n = 0;
    do_write(0, 1, 8'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NC; k++) exp_c[k] = 8'(k);
    checks++;
    if (init_done !== 1'b0 || wr_err !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_commit_flags: done=%b err=%b ready=%b, required 0 0 0", init_done, wr_err, wr_ready);
    end
    while (!init_done && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== NC) begin
      errors++;
      $display("FAIL rst_commit_sweep_len: init_done after %0d cycles, required %0d", n, NC);
    end
    for (int k = 0; k < NC; k++) begin
      read_cell(k / NJ, k % NJ, v);
      checks++;
      if (v !== exp_c[k]) begin
        errors++;
        $display("FAIL rst_commit_cells(%0d,%0d): got %h, required %h", k / NJ, k % NJ, v, exp_c[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_same_edge();
    test_out_of_range();
    test_reset_in_commit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
